// File: rtl/ram_nib_reader_pkg.sv
// rtl/ram_nib_reader_pkg.sv - shared nib geometry, colour codes and reader state encoding
package ram_nib_reader_pkg;

    // Packing geometry shared with the cartridge RAM writer.
    localparam int NIB_WIDTH     = 2;
    localparam int NIBS_PER_WORD = 6;

    typedef logic [NIB_WIDTH-1:0] nib_t;

    // Colour codes carried by each nib; also used by the colour detector and RAM writer.
    localparam nib_t COLOR_RED    = 2'd0;
    localparam nib_t COLOR_GREEN  = 2'd1;
    localparam nib_t COLOR_BLUE   = 2'd2;
    localparam nib_t COLOR_YELLOW = 2'd3;

    // Reader FSM encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_RAM = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_EMIT     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/ram_nib_reader_nib_unpacker.sv
// rtl/ram_nib_reader_nib_unpacker.sv - word shift register that presents nibs MSB-first
module nib_unpacker #(
    parameter int DATA_WIDTH    = 12,
    parameter int NIB_WIDTH     = 2,
    parameter int NIBS_PER_WORD = 6,
    parameter int IDX_WIDTH     = $clog2(NIBS_PER_WORD)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [NIB_WIDTH-1:0]  o_nib,
    output logic                  o_last
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_WIDTH-1:0]  r_idx;

    // Load a fresh word, or move the next nib into the top slot after each accepted nib.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= {r_shift[DATA_WIDTH-NIB_WIDTH-1:0], {NIB_WIDTH{1'b0}}};
            r_idx   <= r_idx + IDX_WIDTH'(1);
        end
    end

    // The current nib is always the top slot of the register, so it is a flop output.
    assign o_nib  = r_shift[DATA_WIDTH-1 -: NIB_WIDTH];
    assign o_last = (r_idx == IDX_WIDTH'(NIBS_PER_WORD - 1));

endmodule

// File: rtl/ram_nib_reader.sv
// rtl/ram_nib_reader.sv - fetches a run of RAM words and streams their colour nibs
module ram_nib_reader #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 12,
    parameter int NIB_WIDTH     = 2,
    parameter int NIBS_PER_WORD = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_startReader,
    input  logic [ADDR_WIDTH-1:0] i_startAddress,
    input  logic [ADDR_WIDTH-1:0] i_wordCount,
    output logic [ADDR_WIDTH-1:0] o_ramAddress,
    input  logic [DATA_WIDTH-1:0] i_ramData,
    output logic [NIB_WIDTH-1:0]  o_nib,
    output logic                  o_nibValid,
    input  logic                  i_nibReady,
    output logic                  o_busy,
    output logic                  o_readerComplete
);

    import ram_nib_reader_pkg::*;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [ADDR_WIDTH-1:0] r_words_left;
    logic                  r_nib_valid;
    logic                  r_busy;
    logic                  r_complete;

    logic                  w_handshake;
    logic                  w_last;
    logic                  w_load;
    logic                  w_shift;
    logic [NIB_WIDTH-1:0]  w_nib;

    // A nib is consumed only while it is being offered; ready alone does nothing.
    assign w_handshake = r_nib_valid && i_nibReady;
    assign w_load      = (r_state == ST_LOAD);
    assign w_shift     = (r_state == ST_EMIT) && w_handshake && !w_last;

    nib_unpacker #(
        .DATA_WIDTH    (DATA_WIDTH),
        .NIB_WIDTH     (NIB_WIDTH),
        .NIBS_PER_WORD (NIBS_PER_WORD)
    ) u_unpacker (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (i_ramData),
        .o_nib   (w_nib),
        .o_last  (w_last)
    );

    // Run sequencing: address/word counters and the valid/busy/complete flags.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_ram_address <= '0;
            r_words_left  <= '0;
            r_nib_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_complete    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_complete <= 1'b0;
                    if (i_startReader) begin
                        if (i_wordCount == '0) begin
                            // Empty run: skip RAM entirely, just report completion.
                            r_state <= ST_DONE;
                        end else begin
                            r_words_left  <= i_wordCount;
                            r_ram_address <= i_startAddress;
                            r_busy        <= 1'b1;
                            r_state       <= ST_WAIT_RAM;
                        end
                    end
                end
                ST_WAIT_RAM: begin
                    // RAM registers the address this cycle; data appears next cycle.
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_nib_valid <= 1'b1;
                    r_state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (w_handshake && w_last) begin
                        r_nib_valid  <= 1'b0;
                        r_words_left <= r_words_left - ADDR_WIDTH'(1);
                        if (r_words_left == ADDR_WIDTH'(1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            // Wraps modulo the address width by design.
                            r_ram_address <= r_ram_address + ADDR_WIDTH'(1);
                            r_state       <= ST_WAIT_RAM;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy     <= 1'b0;
                    r_complete <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ramAddress     = r_ram_address;
    assign o_nib            = w_nib;
    assign o_nibValid       = r_nib_valid;
    assign o_busy           = r_busy;
    assign o_readerComplete = r_complete;

endmodule

// File: tb/tb_ram_nib_reader.sv
// tb/tb_ram_nib_reader.sv - self-checking bench for ram_nib_reader
module tb_ram_nib_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        startReader;
    logic [7:0]  startAddress;
    logic [7:0]  wordCount;
    logic [7:0]  ramAddress;
    logic [11:0] ramData;
    logic [1:0]  nib;
    logic        nibValid;
    logic        nibReady;
    logic        busy;
    logic        readerComplete;

    logic [11:0] mem [0:255];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int exp_q[$];
    int addr_q[$];
    int rise_q[$];
    int accepted, valid_seen, complete_cnt, complete_cyc, first_valid_cyc, start_cyc, last_addr;
    bit mon_en = 1'b0;
    bit prev_hold = 1'b0;
    bit prev_valid = 1'b0;
    logic [1:0] prev_nib;
    int ready_mode = 0;
    int ready_phase = 0;

    always #5 clk = ~clk;

    ram_nib_reader dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_startReader    (startReader),
        .i_startAddress   (startAddress),
        .i_wordCount      (wordCount),
        .o_ramAddress     (ramAddress),
        .i_ramData        (ramData),
        .o_nib            (nib),
        .o_nibValid       (nibValid),
        .i_nibReady       (nibReady),
        .o_busy           (busy),
        .o_readerComplete (readerComplete)
    );

    // Synchronous RAM: data for an address appears one cycle after it is presented.
    always @(posedge clk) begin
        cyc++;
        ramData <= mem[ramAddress];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: a word's nibs in read order are its 2-bit fields from the top down.
    task automatic expect_word(input logic [11:0] w);
        for (int k = 0; k < 6; k++) exp_q.push_back(int'((w >> (10 - 2 * k)) & 12'h3));
    endtask

    task automatic clear_stats();
        accepted = 0;
        valid_seen = 0;
        complete_cnt = 0;
        complete_cyc = -1;
        first_valid_cyc = -1;
        addr_q.delete();
        rise_q.delete();
        last_addr = int'(ramAddress);
        prev_hold = 1'b0;
        prev_valid = nibValid;
        mon_en = 1'b1;
    endtask

    task automatic start_run(input logic [7:0] a, input logic [7:0] n);
        @(posedge clk);
        #1;
        startAddress = a;
        wordCount = n;
        startReader = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        startReader = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (complete_cnt > 0) break;
        end
        check("run_completed", int'(complete_cnt > 0), 1);
        repeat (4) @(negedge clk);
    endtask

    // Consumer ready: always high, or a 1,0,0 repeating pattern.
    initial begin
        nibReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 1) begin
                nibReady = (ready_phase % 3 == 0);
                ready_phase++;
            end else begin
                nibReady = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model queue plus hold/timing bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_nib", int'(nib), int'(prev_nib));
                check("hold_valid", int'(nibValid), 1);
            end
            if (nibValid && !prev_valid) rise_q.push_back(cyc);
            if (nibValid) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (nibValid && nibReady) begin
                if (exp_q.size() == 0) check("extra_nib", 1, 0);
                else check("nib_value", int'(nib), exp_q.pop_front());
                accepted++;
            end
            if (readerComplete) begin
                complete_cnt++;
                complete_cyc = cyc;
            end
            if (int'(ramAddress) != last_addr) begin
                addr_q.push_back(int'(ramAddress));
                last_addr = int'(ramAddress);
            end
            prev_hold = nibValid && !nibReady;
            prev_nib = nib;
            prev_valid = nibValid;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit[6];
        lit = '{3, 2, 1, 0, 0, 1};
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        reset = 1'b0;
        startReader = 1'b0;
        startAddress = 8'd0;
        wordCount = 8'd0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", int'(ramAddress), 0);
        check("rst_nib", int'(nib), 0);
        check("rst_valid", int'(nibValid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_complete", int'(readerComplete), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single word, ready high
        mem[0] = 12'hE41;
        exp_q.delete();
        expect_word(12'hE41);
        for (int i = 0; i < 6; i++) check("model_e41", exp_q[i], lit[i]);
        clear_stats();
        start_run(8'd0, 8'd1);
        @(negedge clk);
        check("t1_busy_running", int'(busy), 1);
        wait_done(40);
        check("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
        check("t1_complete_lat", complete_cyc - start_cyc, 10);
        check("t1_complete_cnt", complete_cnt, 1);
        check("t1_accepted", accepted, 6);
        check("t1_left", exp_q.size(), 0);
        check("t1_busy_after", int'(busy), 0);

        // Three words across the address wrap
        mem[254] = 12'hFFF;
        mem[255] = 12'h000;
        mem[0]   = 12'h555;
        exp_q.delete();
        expect_word(12'hFFF);
        expect_word(12'h000);
        expect_word(12'h555);
        check("model_555_n0", exp_q[12], 1);
        check("model_fff_n5", exp_q[5], 3);
        clear_stats();
        start_run(8'd254, 8'd3);
        wait_done(80);
        check("t2_addr_cnt", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("t2_addr0", addr_q[0], 254);
            check("t2_addr1", addr_q[1], 255);
            check("t2_addr2", addr_q[2], 0);
        end
        check("t2_valid_cycles", valid_seen, 18);
        check("t2_accepted", accepted, 18);
        check("t2_words", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            check("t2_word_spacing0", rise_q[1] - rise_q[0], 8);
            check("t2_word_spacing1", rise_q[2] - rise_q[1], 8);
        end
        check("t2_complete_lat", complete_cyc - start_cyc, 26);
        check("t2_left", exp_q.size(), 0);

        // Back-pressure with ready 1,0,0,...
        mem[0] = 12'hE41;
        exp_q.delete();
        expect_word(12'hE41);
        ready_phase = 0;
        ready_mode = 1;
        clear_stats();
        start_run(8'd0, 8'd1);
        wait_done(80);
        ready_mode = 0;
        check("t3_accepted", accepted, 6);
        check("t3_left", exp_q.size(), 0);
        check("t3_complete_cnt", complete_cnt, 1);

        // Empty run
        exp_q.delete();
        clear_stats();
        start_run(8'd5, 8'd0);
        wait_done(20);
        check("t4_valid_cycles", valid_seen, 0);
        check("t4_addr_changes", addr_q.size(), 0);
        check("t4_complete_lat", complete_cyc - start_cyc, 2);
        check("t4_complete_cnt", complete_cnt, 1);

        // Reset in the middle of a word, then a clean restart
        mem[16] = 12'h1B6;
        mem[17] = 12'hC3A;
        exp_q.delete();
        expect_word(12'h1B6);
        expect_word(12'hC3A);
        clear_stats();
        start_run(8'd16, 8'd2);
        for (int i = 0; i < 40; i++) begin
            if (accepted >= 3) break;
            @(negedge clk);
        end
        check("t5_reached_third", int'(accepted >= 3), 1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("t5_rst_valid", int'(nibValid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_addr", int'(ramAddress), 0);
        check("t5_rst_complete", int'(readerComplete), 0);
        exp_q.delete();
        clear_stats();
        repeat (12) @(negedge clk);
        check("t5_no_complete", complete_cnt, 0);
        check("t5_no_valid", valid_seen, 0);
        expect_word(12'h1B6);
        expect_word(12'hC3A);
        check("model_1b6_n3", exp_q[3], 3);
        check("model_c3a_n0", exp_q[6], 3);
        clear_stats();
        start_run(8'd16, 8'd2);
        wait_done(60);
        check("t5_accepted", accepted, 12);
        check("t5_left", exp_q.size(), 0);
        check("t5_complete_lat", complete_cyc - start_cyc, 18);

        // Second start while busy is ignored
        mem[32]  = 12'h9D2;
        mem[33]  = 12'h2E7;
        mem[128] = 12'hFFF;
        exp_q.delete();
        expect_word(12'h9D2);
        expect_word(12'h2E7);
        clear_stats();
        start_run(8'd32, 8'd2);
        for (int i = 0; i < 40; i++) begin
            if (accepted >= 4) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        startAddress = 8'd128;
        wordCount = 8'd5;
        startReader = 1'b1;
        @(posedge clk);
        #1;
        startReader = 1'b0;
        wait_done(60);
        check("t6_addr_cnt", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            check("t6_addr0", addr_q[0], 32);
            check("t6_addr1", addr_q[1], 33);
        end
        check("t6_accepted", accepted, 12);
        check("t6_left", exp_q.size(), 0);
        check("t6_complete_lat", complete_cyc - start_cyc, 18);
        check("t6_complete_cnt", complete_cnt, 1);
        check("t6_busy_after", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
